bhg_i2c_target: RTL and testbench
=================================

BHG_I2C_TARGET -- requirements
Module: bhg_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h39, 7-bit I2C device address; 8-bit write address is 0x72.
REQ-002 Parameter FILT_LEN, default 3, number of consecutive equal samples required to accept a new scl/sda level.
REQ-003 Parameter REG_INIT, default 8'h00, reset value of every register-file byte.
REQ-004 clk_in  input  1  system clock, at least 8x the I2C bit rate; one clock domain only.
REQ-005 rst_in  input  1  reset, synchronous to clk_in, active-low.
REQ-006 I2C_scl  input  1  I2C clock from the initiator; never driven (no clock stretching).
REQ-007 I2C_sda  inout  1  I2C data, open-drain: driven 0 or high-Z, never driven 1.
REQ-008 busy  output  1  high from an address-matched START until STOP, NACK-to-idle, or address mismatch.
REQ-009 wr_ena  output  1  one-clock strobe per data byte written to the register file.
REQ-010 wr_addr  output  8  register address of the current wr_ena strobe.
REQ-011 wr_data  output  8  data byte of the current wr_ena strobe.
REQ-012 host_addr  input  8  local read-port address.
REQ-013 host_data  output  8  register-file byte at host_addr, registered, 1-clock latency.

Function
REQ-014 scl and sda pass through a 2-FF synchronizer, then a FILT_LEN-sample glitch filter; all decoding uses the filtered levels.
REQ-015 START = filtered sda falling while scl high; STOP = filtered sda rising while scl high; each is detected in any state, including mid-byte.
REQ-016 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
REQ-017 START (including repeated START) -> ADDR, bit counter cleared, sda released; the register pointer is retained.
REQ-018 STOP -> IDLE, sda released, busy low.
REQ-019 Data bits are sampled MSB first on the filtered scl rising edge; sda is driven or released one clock after the filtered scl falling edge.
REQ-020 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR go to ADDR_ACK and drive sda low for the 9th clock; otherwise go to IDLE with no ACK and ignore the bus until the next START.
REQ-021 ADDR_ACK with R/W=0 -> REG; with R/W=1 -> RDATA, loading the shift register from reg[pointer].
REQ-022 REG: the 8 received bits load the pointer; ACK, then go to WDATA.
REQ-023 WDATA: on completion of the 8th bit, write reg[pointer], pulse wr_ena with wr_addr=pointer and wr_data=byte, ACK, increment the pointer.
REQ-024 RDATA: shift the byte out MSB first, then release sda for the 9th clock (RDATA_MACK); the initiator's ACK is sampled on scl rising.
REQ-025 Initiator ACK=0 -> increment the pointer, load the next byte, return to RDATA; NACK=1 -> IDLE with sda released.
REQ-026 The pointer is 8 bits and wraps 0xFF->0x00 on increment, for both reads and writes.
REQ-027 A START or STOP mid-byte discards the partial byte: no write, no wr_ena.
REQ-028 A host read and a simultaneous I2C write to the same address return the old byte on host_data that cycle and the new byte on the next.

Reset
REQ-029 While rst_in=0 on a clk_in edge: state=IDLE, sda high-Z, busy=0, wr_ena=0, wr_addr=0, wr_data=0, pointer=0, host_data=REG_INIT, all register bytes=REG_INIT, filters preset to high.
REQ-030 Reset asserted mid-transfer releases sda within 1 clock; the bus is ignored until the first START after reset release.

Structure
REQ-031 The state enum and the I2C bit and ACK constants belong in the shared package bhg_i2c_pkg, which the initiator also uses.
REQ-032 A single sub-module, bhg_i2c_filter (synchronizer plus glitch filter plus edge outputs), is instantiated once each for scl and sda.

Verification
REQ-033 Write 0x72, 0x98, 0x03 -> three ACKs; one wr_ena pulse with wr_addr=0x98, wr_data=0x03; host_addr=0x98 then reads 0x03.
REQ-034 Write pointer 0x98, repeated START, 0x73, read 2 bytes with ACK then NACK -> returns reg[0x98] and reg[0x99]; sda released after the NACK; busy low after STOP.
REQ-035 Address 0x74 -> sda stays high-Z for the 9th clock; no wr_ena; busy stays 0.
REQ-036 Pointer 0xFF, write 0xAA, 0xBB -> reg[0xFF]=0xAA, reg[0x00]=0xBB.
REQ-037 STOP after 4 data bits -> no wr_ena, state IDLE; the next transaction completes normally.
REQ-038 rst_in=0 while the target drives an ACK low -> sda high-Z within 1 clock; all outputs at reset values.

Source files
------------

// File: rtl/bhg_i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus bit/ACK levels and address decode helper.
package bhg_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK
    } i2c_state_t;

    localparam logic       I2C_ACK   = 1'b0;
    localparam logic       I2C_NACK  = 1'b1;
    localparam logic       I2C_WR    = 1'b0;
    localparam logic       I2C_RD    = 1'b1;
    localparam logic [3:0] BYTE_BITS = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
        return addr_byte[7:1] == dev;
    endfunction

endpackage

// File: rtl/bhg_i2c_filter.sv
// Two-flop synchronizer followed by an N-sample majority-free glitch filter with edge strobes.
module bhg_i2c_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]          sync;
    logic [FILT_LEN-1:0] hist;

    // A new level is accepted only after FILT_LEN identical synchronized samples.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync  <= 2'b11;
            hist  <= '1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            hist <= {hist[FILT_LEN-2:0], sync[1]};
            rise <= 1'b0;
            fall <= 1'b0;
            if ((&hist) && !level) begin
                level <= 1'b1;
                rise  <= 1'b1;
            end else if (!(|hist) && level) begin
                level <= 1'b0;
                fall  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bhg_i2c_target.sv
// I2C target with a 256-byte register file, auto-incrementing pointer and a local read port.
module bhg_i2c_target
    import bhg_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       I2C_scl,
    inout  wire        I2C_sda,
    output logic       busy,
    output logic       wr_ena,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] host_addr,
    output logic [7:0] host_data
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    bhg_i2c_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_in(clk_in), .rst_in(rst_in), .line(I2C_scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    bhg_i2c_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_in(clk_in), .rst_in(rst_in), .line(I2C_sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t state, state_next;
    logic [3:0] bit_cnt;
    logic [7:0] shift, ptr, ptr_inc, rx_byte;
    logic       rw, mack, sda_low, scl_fall_d;
    logic       start_det, stop_det, byte_end, wr_strobe;
    logic [7:0] regs [256];

    assign I2C_sda   = sda_low ? 1'b0 : 1'bz;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    // Bus actions happen one clock after the filtered scl falling edge.
    assign byte_end  = scl_fall_d && (bit_cnt == BYTE_BITS);
    assign rx_byte   = {shift[6:0], sda_lvl};
    assign ptr_inc   = ptr + 8'd1;
    assign wr_strobe = (state == ST_WDATA) && scl_rise && (bit_cnt == 4'd7)
                       && !start_det && !stop_det;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_ADDR:       if (byte_end) state_next = addr_match(shift, DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:   if (scl_fall_d) state_next = (rw == I2C_RD) ? ST_RDATA : ST_REG;
                ST_REG:        if (byte_end) state_next = ST_REG_ACK;
                ST_REG_ACK:    if (scl_fall_d) state_next = ST_WDATA;
                ST_WDATA:      if (byte_end) state_next = ST_WDATA_ACK;
                ST_WDATA_ACK:  if (scl_fall_d) state_next = ST_WDATA;
                ST_RDATA:      if (byte_end) state_next = ST_RDATA_MACK;
                ST_RDATA_MACK: if (scl_fall_d) state_next = (mack == I2C_ACK) ? ST_RDATA : ST_IDLE;
                default:       state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 256; i++) regs[i] <= REG_INIT;
            host_data <= REG_INIT;
        end else begin
            if (wr_strobe) regs[ptr] <= rx_byte;
            host_data <= regs[host_addr];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            rw         <= I2C_WR;
            mack       <= I2C_NACK;
            sda_low    <= 1'b0;
            busy       <= 1'b0;
            wr_ena     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            scl_fall_d <= 1'b0;
        end else begin
            scl_fall_d <= scl_fall;
            wr_ena     <= wr_strobe;
            if (wr_strobe) begin
                wr_addr <= ptr;
                wr_data <= rx_byte;
                ptr     <= ptr_inc;
            end
            // START/STOP abandon any partial byte; the pointer survives a repeated START.
            if (start_det) begin
                bit_cnt <= '0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                bit_cnt <= '0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (scl_rise && bit_cnt != BYTE_BITS) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (byte_end) begin
                            bit_cnt <= '0;
                            if (state == ST_ADDR) begin
                                if (addr_match(shift, DEV_ADDR)) begin
                                    sda_low <= 1'b1;
                                    busy    <= 1'b1;
                                    rw      <= shift[0];
                                end else begin
                                    busy <= 1'b0;
                                end
                            end else begin
                                sda_low <= 1'b1;
                                if (state == ST_REG) ptr <= shift;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall_d) begin
                        if (rw == I2C_RD) begin
                            shift   <= regs[ptr];
                            sda_low <= ~regs[ptr][7];
                        end else begin
                            sda_low <= 1'b0;
                        end
                    end
                    ST_REG_ACK, ST_WDATA_ACK: if (scl_fall_d) sda_low <= 1'b0;
                    ST_RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall_d) begin
                            if (bit_cnt == BYTE_BITS) begin
                                sda_low <= 1'b0;
                                bit_cnt <= '0;
                            end else begin
                                sda_low <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_MACK: begin
                        if (scl_rise) mack <= sda_lvl;
                        if (scl_fall_d) begin
                            if (mack == I2C_ACK) begin
                                ptr     <= ptr_inc;
                                shift   <= regs[ptr_inc];
                                sda_low <= ~regs[ptr_inc][7];
                            end else begin
                                busy    <= 1'b0;
                                sda_low <= 1'b0;
                            end
                        end
                    end
                    default: sda_low <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bhg_i2c_target.sv
// Bit-banged I2C initiator driving bhg_i2c_target against a byte-array register model.
module tb_bhg_i2c_target;

    localparam int         Q        = 16;
    localparam logic [7:0] REG_INIT = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_drv_low;
    logic [7:0] host_addr;
    logic       busy, wr_ena;
    logic [7:0] wr_addr, wr_data, host_data;
    wire        sda_line;

    assign sda_line = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda_line);

    always #5 clk = ~clk;

    bhg_i2c_target dut (
        .clk_in(clk), .rst_in(rst_n), .I2C_scl(scl), .I2C_sda(sda_line),
        .busy(busy), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_addr(host_addr), .host_data(host_data)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] wr_q [$];
    logic        coll_seen;
    logic [7:0]  coll_old, coll_new;

    // Record every register-file write; capture host_data around a same-address write.
    always @(negedge clk) begin
        if (wr_ena) begin
            wr_q.push_back({wr_addr, wr_data});
            if (wr_addr == host_addr) begin
                coll_seen = 1'b1;
                coll_old  = host_data;
                @(negedge clk);
                coll_new  = host_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q(input int n = 1);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv_low = 1'b0; wait_q();
        scl = 1'b1;         wait_q();
        sda_drv_low = 1'b1; wait_q();
        scl = 1'b0;         wait_q();
    endtask

    task automatic i2c_stop();
        sda_drv_low = 1'b1; wait_q();
        scl = 1'b1;         wait_q();
        sda_drv_low = 1'b0; wait_q(2);
    endtask

    task automatic send_bit(input logic b);
        sda_drv_low = ~b; wait_q();
        scl = 1'b1;       wait_q(2);
        scl = 1'b0;       wait_q();
    endtask

    task automatic recv_bit(output logic b);
        sda_drv_low = 1'b0; wait_q();
        scl = 1'b1;         wait_q();
        b = sda_line;       wait_q();
        scl = 1'b0;         wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
        sda_drv_low = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] p, input logic [7:0] data [$]);
        logic       ack;
        logic [7:0] a;
        wr_q.delete();
        i2c_start();
        write_byte(8'h72, ack); check("wr_addr_ack", ack, 0);
        check("wr_busy", busy, 1);
        write_byte(p, ack);     check("wr_reg_ack", ack, 0);
        foreach (data[i]) begin
            write_byte(data[i], ack); check("wr_data_ack", ack, 0);
        end
        i2c_stop();
        check("wr_busy_after_stop", busy, 0);
        check("wr_count", wr_q.size(), data.size());
        if (wr_q.size() == data.size()) begin
            foreach (data[i]) begin
                a = p + 8'(i);
                check("wr_event", wr_q[i], {a, data[i]});
            end
        end
        foreach (data[i]) begin
            a = p + 8'(i);
            model_mem[a] = data[i];
        end
        model_ptr = p + 8'(data.size());
    endtask

    task automatic read_body(input int n);
        logic       ack;
        logic [7:0] d;
        write_byte(8'h73, ack); check("rd_addr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            check("rd_data", d, model_mem[8'(model_ptr + 8'(i))]);
        end
        repeat (4) @(negedge clk);
        check("rd_sda_released", sda_line, 1);
        check("rd_busy_after_nack", busy, 0);
        i2c_stop();
        check("rd_busy_after_stop", busy, 0);
        model_ptr = model_ptr + 8'(n - 1);
    endtask

    task automatic do_read(input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        write_byte(8'h72, ack); check("rd_waddr_ack", ack, 0);
        write_byte(p, ack);     check("rd_reg_ack", ack, 0);
        model_ptr = p;
        i2c_start();
        read_body(n);
    endtask

    task automatic do_cur_read(input int n);
        i2c_start();
        read_body(n);
    endtask

    task automatic host_read(input logic [7:0] a);
        host_addr = a;
        @(negedge clk);
        check("host_data", host_data, model_mem[a]);
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] p, b72;
        logic       ack;
        int         n;

        foreach (model_mem[i]) model_mem[i] = REG_INIT;
        model_ptr   = 8'h00;
        rst_n       = 1'b0;
        scl         = 1'b1;
        sda_drv_low = 1'b0;
        host_addr   = 8'h55;
        coll_seen   = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wr_ena", wr_ena, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_host_data", host_data, REG_INIT);
        check("rst_sda", sda_line, 1);
        rst_n = 1'b1;
        wait_q();

        // Basic write, with the host port watching the same address.
        host_addr = 8'h98;
        q = '{8'h03};
        do_write(8'h98, q);
        check("coll_seen", coll_seen, 1);
        check("coll_old", coll_old, 8'h00);
        check("coll_new", coll_new, 8'h03);
        host_read(8'h98);

        // Pointer wrap on write.
        q = '{8'hAA, 8'hBB};
        do_write(8'hFF, q);
        host_read(8'hFF);
        host_read(8'h00);

        // Random bursts.
        repeat (3) begin
            p = 8'($urandom);
            n = $urandom_range(1, 3);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_write(p, q);
            for (int i = 0; i < n; i++) host_read(p + 8'(i));
        end

        // Read back through a repeated START.
        q = '{8'($urandom)};
        do_write(8'h99, q);
        do_read(8'h98, 2);

        repeat (2) begin
            do_read(8'($urandom), $urandom_range(1, 3));
        end

        // Wrong device address is ignored.
        wr_q.delete();
        i2c_start();
        write_byte(8'h74, ack); check("nomatch_ack", ack, 1);
        check("nomatch_busy", busy, 0);
        write_byte(8'h10, ack); check("nomatch_data_ack", ack, 1);
        i2c_stop();
        check("nomatch_wr_count", wr_q.size(), 0);
        check("nomatch_busy_end", busy, 0);

        // STOP mid-byte discards the partial byte.
        wr_q.delete();
        i2c_start();
        write_byte(8'h72, ack); check("part_addr_ack", ack, 0);
        write_byte(8'h40, ack); check("part_reg_ack", ack, 0);
        model_ptr = 8'h40;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        check("part_wr_count", wr_q.size(), 0);
        check("part_busy", busy, 0);
        do_cur_read(2);
        q = '{8'h9E};
        do_write(8'h41, q);
        host_read(8'h41);

        // Reset while the target is driving ACK.
        b72 = 8'h72;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(b72[i]);
        sda_drv_low = 1'b0; wait_q();
        scl = 1'b1;         wait_q();
        check("rst_mid_ack_driven", sda_line, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_sda", sda_line, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wr_ena", wr_ena, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        check("rst_mid_host_data", host_data, REG_INIT);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
        check("rst_after_busy", busy, 0);
        foreach (model_mem[i]) model_mem[i] = REG_INIT;
        model_ptr = 8'h00;
        host_read(8'h41);
        do_cur_read(1);
        q = '{8'h77};
        do_write(8'h10, q);
        host_read(8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
